// File: rtl/serv_lsu_serdes_if.sv
// Data-bus bundle between the load/store serdes (master) and the Wishbone-style
// memory port (slave).
interface serv_lsu_serdes_if;
  logic [31:0] dbus_adr;
  logic [31:0] dbus_dat;
  logic [3:0]  dbus_sel;
  logic        dbus_we;
  logic        dbus_cyc;
  logic [31:0] dbus_rdt;
  logic        dbus_ack;

  modport master (
    output dbus_adr, dbus_dat, dbus_sel, dbus_we, dbus_cyc,
    input  dbus_rdt, dbus_ack
  );

  modport slave (
    input  dbus_adr, dbus_dat, dbus_sel, dbus_we, dbus_cyc,
    output dbus_rdt, dbus_ack
  );
endinterface

// File: rtl/serv_lsu_serdes.sv
// Bit-serial load/store unit: serial store operand in, one data-bus cycle, serial
// load result out. Define SERV_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module serv_lsu_serdes (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_we,
  input  logic [1:0]        i_size,
  input  logic              i_signed,
  input  logic [1:0]        i_lsb,
  input  logic [31:0]       i_adr,
  input  logic              i_rs2,
  output logic              o_rd,
  output logic              o_rd_valid,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_misalign,
  serv_lsu_serdes_if.master dbus
);

  typedef enum logic [1:0] {StIdle, StShiftIn, StBus, StShiftOut} state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [31:0] sr_q;
  logic        we_q, signed_q;
  logic [1:0]  size_q, lsb_q;
  logic [31:0] adr_q, dat_q;
  logic [3:0]  sel_q;
  logic        cyc_q, bus_we_q, rd_valid_q, done_q, misalign_q;

  logic [3:0]  sel_start;
  logic        misalign;
  logic [31:0] sr_in, dat_next, rdt_algn, ld_ext;

`ifdef SERV_MISALIGN_TRAP_EN
  assign misalign = ((i_size == 2'b01) && i_lsb[0]) || (i_size[1] && (i_lsb != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    sel_start = 4'b1111;
    case (i_size)
      2'b00:   sel_start = 4'b0001 << i_lsb;
      2'b01:   sel_start = i_lsb[1] ? 4'b1100 : 4'b0011;
      default: sel_start = 4'b1111;
    endcase

    // Store data includes the bit arriving on the final SHIFT_IN edge.
    sr_in    = {i_rs2, sr_q[31:1]};
    dat_next = sr_in;
    case (size_q)
      2'b00:   dat_next = {4{sr_in[7:0]}};
      2'b01:   dat_next = {2{sr_in[15:0]}};
      default: dat_next = sr_in;
    endcase

    rdt_algn = dbus.dbus_rdt >> {lsb_q, 3'b000};
    ld_ext   = rdt_algn;
    case (size_q)
      2'b00:   ld_ext = {{24{signed_q & rdt_algn[7]}}, rdt_algn[7:0]};
      2'b01:   ld_ext = {{16{signed_q & rdt_algn[15]}}, rdt_algn[15:0]};
      default: ld_ext = rdt_algn;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StIdle;
      cnt_q      <= 5'd0;
      sr_q       <= 32'd0;
      we_q       <= 1'b0;
      signed_q   <= 1'b0;
      size_q     <= 2'b00;
      lsb_q      <= 2'b00;
      adr_q      <= 32'd0;
      dat_q      <= 32'd0;
      sel_q      <= 4'd0;
      cyc_q      <= 1'b0;
      bus_we_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (i_start) begin
            we_q     <= i_we;
            size_q   <= i_size;
            signed_q <= i_signed;
            lsb_q    <= i_lsb;
            adr_q    <= i_adr;
            sel_q    <= sel_start;
            cnt_q    <= 5'd0;
            if (misalign) begin
              done_q     <= 1'b1;
              misalign_q <= 1'b1;
            end else if (i_we) begin
              state_q <= StShiftIn;
            end else begin
              state_q <= StBus;
              cyc_q   <= 1'b1;
            end
          end
        end
        StShiftIn: begin
          sr_q  <= sr_in;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q  <= StBus;
            dat_q    <= dat_next;
            cyc_q    <= 1'b1;
            bus_we_q <= 1'b1;
          end
        end
        StBus: begin
          if (dbus.dbus_ack) begin
            cyc_q    <= 1'b0;
            bus_we_q <= 1'b0;
            if (we_q) begin
              state_q <= StIdle;
              done_q  <= 1'b1;
            end else begin
              sr_q       <= ld_ext;
              cnt_q      <= 5'd0;
              rd_valid_q <= 1'b1;
              state_q    <= StShiftOut;
            end
          end
        end
        StShiftOut: begin
          sr_q  <= {1'b0, sr_q[31:1]};
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q    <= StIdle;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign dbus.dbus_adr = adr_q;
  assign dbus.dbus_dat = dat_q;
  assign dbus.dbus_sel = sel_q;
  assign dbus.dbus_we  = bus_we_q;
  assign dbus.dbus_cyc = cyc_q;

  assign o_rd       = sr_q[0] & rd_valid_q;
  assign o_rd_valid = rd_valid_q;
  assign o_busy     = (state_q != StIdle);
  assign o_done     = done_q;
  assign o_misalign = misalign_q;

endmodule

// File: tb/tb_serv_lsu_serdes.sv
// Self-checking bench for serv_lsu_serdes: directed vector table, hand-written
// reset/ignore sequences and randomized transactions against an arithmetic model.
module tb_serv_lsu_serdes;

`ifdef SERV_MISALIGN_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [1:0]  lsb;
    logic [31:0] adr;
    logic [31:0] data;
    logic [31:0] rdt;
    int          waits;
    bit          noise;
    logic [31:0] exp_dat;
    logic [3:0]  exp_sel;
    logic [31:0] exp_rd;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, start, we, sgn, rs2;
  logic [1:0]  size, lsb;
  logic [31:0] adr;
  logic        rd, rd_valid, busy, done, mis;
  int          n_checks = 0;
  int          n_fail = 0;

  serv_lsu_serdes_if dbus ();

  serv_lsu_serdes dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_we       (we),
    .i_size     (size),
    .i_signed   (sgn),
    .i_lsb      (lsb),
    .i_adr      (adr),
    .i_rs2      (rs2),
    .o_rd       (rd),
    .o_rd_valid (rd_valid),
    .o_busy     (busy),
    .o_done     (done),
    .o_misalign (mis),
    .dbus       (dbus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit trap_expected(input logic [1:0] s, input logic [1:0] l);
    return TrapEn && ((s == 2'd1 && (l % 2) == 1) || (s >= 2'd2 && l != 2'd0));
  endfunction

  function automatic vec_t mk(input logic w, input logic [1:0] s, input logic g,
                              input logic [1:0] l, input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] r, input int wt, input bit nz,
                              input logic [31:0] ed, input logic [3:0] es,
                              input logic [31:0] er);
    vec_t v;
    v.we = w; v.size = s; v.sgn = g; v.lsb = l; v.adr = a; v.data = d; v.rdt = r;
    v.waits = wt; v.noise = nz; v.exp_dat = ed; v.exp_sel = es; v.exp_rd = er;
    return v;
  endfunction

  // Reference: access width in bytes, byte lanes as a bit mask, values by arithmetic.
  function automatic vec_t model(input vec_t v);
    vec_t        m = v;
    int          n = (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : 4;
    int          off = (n == 4) ? 0 : (n == 2) ? (int'(v.lsb) / 2) * 2 : int'(v.lsb);
    longint      mask = (64'd1 << (8 * n)) - 1;
    longint      stored = longint'(v.data) & mask;
    longint      dat = 0;
    longint      val;
    for (int i = 0; i < 4 / n; i++) dat = dat + (stored << (8 * n * i));
    val = (longint'(v.rdt) >> (8 * int'(v.lsb))) & mask;
    if (v.sgn && n < 4 && val >= (mask + 1) / 2) val = val + 64'h1_0000_0000 - (mask + 1);
    m.exp_sel = 4'(((1 << n) - 1) << off);
    m.exp_dat = 32'(dat);
    m.exp_rd  = 32'(val);
    return m;
  endfunction

  task automatic run(input vec_t v, input string tag);
    bit          exp_mis = trap_expected(v.size, v.lsb);
    bit          stable = 1'b1, mis_seen = 1'b0;
    int          cyc_cnt = 0, nbits = 0, done_t = -1, ack_c = -1, valid_c = -1;
    logic [31:0] cap_adr = 0, cap_dat = 0, rd_bits = 0;
    logic [3:0]  cap_sel = 0;
    logic        cap_we = 0;
    start = 1'b1; we = v.we; size = v.size; sgn = v.sgn; lsb = v.lsb; adr = v.adr;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 200 && done_t < 0; c++) begin
      if (v.we && c <= 32) rs2 = v.data[c-1];
      if (v.noise && c == 5) begin
        start = 1'b1; we = ~v.we; size = ~v.size; lsb = ~v.lsb; adr = ~v.adr; sgn = ~v.sgn;
      end else begin
        start = 1'b0;
      end
      if (dbus.dbus_cyc) begin
        if (cyc_cnt == 0) begin
          cap_adr = dbus.dbus_adr; cap_dat = dbus.dbus_dat;
          cap_sel = dbus.dbus_sel; cap_we = dbus.dbus_we;
        end else if (cap_adr !== dbus.dbus_adr || cap_dat !== dbus.dbus_dat ||
                     cap_sel !== dbus.dbus_sel || cap_we !== dbus.dbus_we) begin
          stable = 1'b0;
        end
        dbus.dbus_ack = (cyc_cnt == v.waits);
        if (dbus.dbus_ack) ack_c = c;
        dbus.dbus_rdt = dbus.dbus_ack ? v.rdt : $urandom;
        cyc_cnt++;
      end else begin
        dbus.dbus_ack = v.noise && c <= 3;
        dbus.dbus_rdt = $urandom;
      end
      if (rd_valid) begin
        if (valid_c < 0) valid_c = c;
        if (nbits < 32) rd_bits[nbits] = rd;
        nbits++;
      end
      if (mis) mis_seen = 1'b1;
      if (done) done_t = c - 1;
      @(posedge clk); #1;
    end
    dbus.dbus_ack = 1'b0;
    start = 1'b0;
    if (exp_mis) begin
      check({tag, " trap_done_t"}, 32'(done_t), 32'd0);
      check({tag, " trap_misalign"}, 32'(mis_seen), 32'd1);
      check({tag, " trap_no_cyc"}, 32'(cyc_cnt), 32'd0);
    end else begin
      check({tag, " done_latency"}, 32'(done_t), 32'(33 + v.waits));
      check({tag, " misalign_low"}, 32'(mis_seen), 32'd0);
      check({tag, " adr"}, cap_adr, v.adr);
      check({tag, " sel"}, 32'(cap_sel), 32'(v.exp_sel));
      check({tag, " we"}, 32'(cap_we), 32'(v.we));
      check({tag, " bus_stable"}, 32'(stable), 32'd1);
      if (v.we) begin
        check({tag, " dat"}, cap_dat, v.exp_dat);
      end else begin
        check({tag, " rd_value"}, rd_bits, v.exp_rd);
        check({tag, " rd_bits"}, 32'(nbits), 32'd32);
        check({tag, " rd_start"}, 32'(valid_c), 32'(ack_c + 1));
      end
    end
    check({tag, " done_width"}, 32'(done), 32'd0);
    check({tag, " idle_after"}, 32'(busy), 32'd0);
  endtask

  vec_t vecs[11];
  vec_t rv;
  bit   seen;

  initial begin
    vecs[0]  = mk(1, 2'd2, 0, 2'd0, 32'h100, 32'hDEADBEEF, 0, 3, 0, 32'hDEADBEEF, 4'b1111, 0);
    vecs[1]  = mk(1, 2'd0, 0, 2'd2, 32'h204, 32'h000000A5, 0, 0, 0, 32'hA5A5A5A5, 4'b0100, 0);
    vecs[2]  = mk(0, 2'd0, 1, 2'd3, 32'h300, 0, 32'h80000000, 2, 0, 0, 4'b1000, 32'hFFFFFF80);
    vecs[3]  = mk(0, 2'd1, 0, 2'd2, 32'h304, 0, 32'h80011234, 1, 0, 0, 4'b1100, 32'h00008001);
    vecs[4]  = mk(1, 2'd1, 0, 2'd2, 32'h400, 32'h1234BEEF, 0, 1, 1, 32'hBEEFBEEF, 4'b1100, 0);
    vecs[5]  = mk(0, 2'd1, 1, 2'd0, 32'h500, 0, 32'h1234F00D, 5, 1, 0, 4'b0011, 32'hFFFFF00D);
    vecs[6]  = mk(0, 2'd3, 1, 2'd0, 32'h600, 0, 32'hCAFEF00D, 0, 0, 0, 4'b1111, 32'hCAFEF00D);
    vecs[7]  = mk(0, 2'd1, 0, 2'd1, 32'h700, 0, 32'hAABBCCDD, 0, 0, 0, 4'b0011, 32'h0000BBCC);
    vecs[8]  = mk(0, 2'd2, 0, 2'd2, 32'h800, 0, 32'h11223344, 0, 0, 0, 4'b1111, 32'h00001122);
    vecs[9]  = mk(1, 2'd0, 0, 2'd1, 32'h900, 32'hFFFFFF3C, 0, 2, 0, 32'h3C3C3C3C, 4'b0010, 0);
    vecs[10] = mk(0, 2'd0, 0, 2'd1, 32'hA00, 0, 32'h12345678, 0, 0, 0, 4'b0010, 32'h00000056);

    rst = 1'b1; start = 1'b0; we = 1'b0; size = 2'd0; sgn = 1'b0; lsb = 2'd0;
    adr = 32'd0; rs2 = 1'b0; dbus.dbus_ack = 1'b0; dbus.dbus_rdt = 32'd0;
    @(posedge clk); @(posedge clk); #1;
    check("rst busy", 32'(busy), 0);
    check("rst cyc", 32'(dbus.dbus_cyc), 0);
    check("rst we", 32'(dbus.dbus_we), 0);
    check("rst adr", dbus.dbus_adr, 0);
    check("rst dat", dbus.dbus_dat, 0);
    check("rst sel", 32'(dbus.dbus_sel), 0);
    check("rst rd", {30'd0, rd_valid, rd}, 0);
    check("rst done_mis", {30'd0, done, mis}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Ack while idle must not start anything.
    dbus.dbus_ack = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    dbus.dbus_ack = 1'b0;
    check("idle_ack busy", 32'(busy), 0);
    check("idle_ack cyc", 32'(dbus.dbus_cyc), 0);
    check("idle_ack done", 32'(done), 0);

    for (int i = 0; i < 11; i++) run(vecs[i], $sformatf("vec%0d", i));

    // Reset while the bus cycle waits for ack.
    start = 1'b1; we = 1'b0; size = 2'd2; sgn = 1'b0; lsb = 2'd0; adr = 32'hB00;
    @(posedge clk); #1;
    start = 1'b0;
    check("rst_mid cyc_before", 32'(dbus.dbus_cyc), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid cyc_after", 32'(dbus.dbus_cyc), 0);
    check("rst_mid busy_after", 32'(busy), 0);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (done) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("rst_mid no_done", 32'(seen), 0);
    run(vecs[2], "post_rst");

    for (int i = 0; i < 40; i++) begin
      rv.we = 1'($urandom); rv.size = 2'($urandom); rv.sgn = 1'($urandom);
      rv.lsb = 2'($urandom); rv.adr = {$urandom, 2'b00} & 32'hFFFF_FFFC;
      rv.data = $urandom; rv.rdt = $urandom; rv.waits = $urandom_range(0, 4);
      rv.noise = 1'($urandom);
      run(model(rv), $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/serv_lsu_serdes.md
# serv_lsu_serdes

Bit-serial load/store data unit sitting directly downstream of the bit-serial address buffer register. It takes the word-aligned data-bus address and the two address LSBs that the buffer register produces. It collects the 32-bit serial store operand, aligns it and generates the byte selects, then runs one Wishbone-style data-bus cycle. For loads it aligns and sign/zero-extends the returned word and shifts it back out LSB-first to the register file.

## Interface
Parameters:
- none

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset; synchronous, active-high. Clock is i_clk.
- i_start  in  1  one-cycle request pulse; sampled only in IDLE
- i_we  in  1  1 = store, 0 = load; sampled with i_start
- i_size  in  2  00 byte, 01 half, 10 word (11 treated as word); sampled with i_start
- i_signed  in  1  load sign-extend; sampled with i_start
- i_lsb  in  2  address bits [1:0] from the buffer register; sampled with i_start
- i_adr  in  32  word-aligned address ({adr[31:2],2'b00}); sampled with i_start
- i_rs2  in  1  serial store data, LSB first, during SHIFT_IN
- o_rd  out  1  serial load result, LSB first
- o_rd_valid  out  1  high during the 32 SHIFT_OUT cycles
- o_dbus_adr  out  32  latched address
- o_dbus_dat  out  32  aligned store data
- o_dbus_sel  out  4  byte enables
- o_dbus_we  out  1  write strobe; high only in BUS for stores
- o_dbus_cyc  out  1  bus request
- i_dbus_rdt  in  32  read data
- i_dbus_ack  in  1  bus acknowledge
- o_busy  out  1  state != IDLE
- o_done  out  1  one-cycle completion pulse
- o_misalign  out  1  one-cycle misalignment pulse (macro-dependent)

## Operation
- FSM states: IDLE, SHIFT_IN, BUS, SHIFT_OUT. A 5-bit counter handles the shift phases.
- IDLE + i_start:
  - Latch i_we, i_size, i_signed, i_lsb and i_adr.
  - Store: next state SHIFT_IN. Load: next state BUS.
- SHIFT_IN:
  - Each edge shifts i_rs2 into bit 31 of a 32-bit register (right shift).
  - After 32 edges, go to BUS.
  - On entry to BUS, o_dbus_dat is set by size: byte = {4{d[7:0]}}, half = {2{d[15:0]}}, word = d.
- o_dbus_sel, computed at latch time:
  - byte = 4'b0001 << lsb
  - half = lsb[1] ? 1100 : 0011
  - word = 1111
- BUS:
  - o_dbus_cyc = 1. o_dbus_we = latched we.
  - Hold every bus output stable until i_dbus_ack.
  - Ack on a store: go to IDLE and pulse o_done.
  - Ack on a load: capture w = i_dbus_rdt >> (8*lsb). Extract byte/half/word and extend (sign-extend if i_signed, else zero-extend) into the shift register. Go to SHIFT_OUT.
- SHIFT_OUT:
  - o_rd = shift register bit 0; o_rd_valid = 1.
  - Shift right once per edge. After 32 edges, go to IDLE and pulse o_done.
- i_start outside IDLE is ignored. i_dbus_ack outside BUS is ignored.
- Reset values:
  - state IDLE, counter 0, shift register 0
  - o_dbus_adr 0, o_dbus_dat 0, o_dbus_sel 0
  - o_dbus_cyc 0, o_dbus_we 0, o_rd_valid 0, o_rd 0
  - o_done 0, o_misalign 0, o_busy 0
- Reset mid-operation returns to IDLE on that edge, so o_dbus_cyc is low the next cycle. No o_done is produced.

## Timing
- Start at edge E0.
- Store:
  - i_rs2 bit k is sampled at edge E0+1+k (k = 0..31).
  - o_dbus_cyc is high from the cycle after E0+32.
  - Ack sampled at edge Ea gives o_done high in the cycle after Ea.
  - Minimum: o_done 34 cycles after start (ack in the first BUS cycle).
- Load:
  - o_dbus_cyc is high in the cycle after E0.
  - With ack at Ea, o_rd carries bit k in cycle Ea+k.
  - o_done is high in the cycle after the 32nd shift. Minimum 34 cycles.
- Zero-wait ack (ack in the first cycle cyc is high) is legal. Arbitrary wait states are legal.
- o_done and o_misalign are registered, exactly one cycle wide.

## Configuration
- SERV_MISALIGN_TRAP_EN defined:
  - A half access with lsb[0]=1, or a word access with lsb≠00, is misaligned.
  - It never enters SHIFT_IN or BUS, and o_dbus_cyc stays 0.
  - o_misalign and o_done pulse together in the cycle after start; state stays IDLE.
- Not defined:
  - o_misalign is tied 0 and no check is made.
  - Misaligned accesses proceed using the sel/alignment rules above (word sel 1111, rdt shift by 8*lsb).

## Test plan
- Word store: adr 0x100, lsb 00, serial rs2 0xDEADBEEF, ack after 3 wait states -> dat 0xDEADBEEF, sel 1111, we 1, o_done 1 cycle after ack.
- Byte store: lsb 10, rs2 0x000000A5 -> dat 0xA5A5A5A5, sel 0100.
- Signed byte load: lsb 11, rdt 0x80000000 -> o_rd serial 0xFFFFFF80. Unsigned half load: lsb 10, rdt 0x8001xxxx -> 0x00008001.
- Reset asserted during BUS wait -> cyc low the next cycle, no o_done; a following load completes normally.
- With SERV_MISALIGN_TRAP_EN: half load with lsb 01 -> o_misalign and o_done pulse, cyc never asserted. Without the macro: bus cycle issued with sel 0011.
- i_start pulsed while busy and ack pulsed while in IDLE -> both ignored; the transaction in flight is unchanged.
